// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder: oversamples SCK/CSX/SDI/DC in the CLK_100MHz domain and
// hands each completed byte, tagged with its DC level, to a valid/ack consumer.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic       CLK_100MHz,
  input  logic       RESET,
  input  logic       SCK,
  input  logic       CSX,
  input  logic       SDI,
  input  logic       DC,
  input  logic       ACK,
  output logic [7:0] OUT,
  output logic       OUT_DC,
  output logic       VALID,
  output logic       OVERRUN,
  output logic       BUSY,
  output logic [7:0] BYTE_COUNT
);

  localparam int LAST = SYNC_STAGES - 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  logic [LAST:0] sck_sync_reg;
  logic [LAST:0] csx_sync_reg;
  logic [LAST:0] sdi_sync_reg;
  logic [LAST:0] dc_sync_reg;
  logic          sck_prev_reg;

  state_t        state_reg, state_next;
  logic          csx_fall;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_next;
  logic [7:0]    done_byte_reg;
  logic          done_dc_reg;
  logic          commit_reg;

  logic sck_s, csx_s, sdi_s, dc_s, sck_rise;

  assign sck_s    = sck_sync_reg[LAST];
  assign csx_s    = csx_sync_reg[LAST];
  assign sdi_s    = sdi_sync_reg[LAST];
  assign dc_s     = dc_sync_reg[LAST];
  assign sck_rise = sck_s & ~sck_prev_reg;
  assign BUSY     = ~csx_s;

  assign shift_next = MSB_FIRST ? {shift_reg[6:0], sdi_s} : {sdi_s, shift_reg[7:1]};

  // Synchronisers reset to the idle bus levels so release from reset looks like a quiet bus.
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      sck_sync_reg <= '0;
      csx_sync_reg <= '1;
      sdi_sync_reg <= '0;
      dc_sync_reg  <= '0;
      sck_prev_reg <= 1'b0;
    end else begin
      sck_sync_reg <= {sck_sync_reg[LAST-1:0], SCK};
      csx_sync_reg <= {csx_sync_reg[LAST-1:0], CSX};
      sdi_sync_reg <= {sdi_sync_reg[LAST-1:0], SDI};
      dc_sync_reg  <= {dc_sync_reg[LAST-1:0], DC};
      sck_prev_reg <= sck_s;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    csx_fall   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!csx_s) begin
          state_next = ST_SHIFT;
          csx_fall   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (csx_s) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Assembly stage: the finished byte is parked in done_* so a CSX rise right after
  // the 8th edge cannot disturb the commit on the following cycle.
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      done_byte_reg <= 8'h00;
      done_dc_reg   <= 1'b0;
      commit_reg    <= 1'b0;
    end else begin
      commit_reg <= 1'b0;
      if (state_reg == ST_IDLE || csx_s) begin
        bit_cnt_reg <= 3'd0;
        shift_reg   <= 8'h00;
      end else if (sck_rise) begin
        shift_reg   <= shift_next;
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          done_byte_reg <= shift_next;
          done_dc_reg   <= dc_s;
          commit_reg    <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      OUT        <= 8'h00;
      OUT_DC     <= 1'b0;
      VALID      <= 1'b0;
      OVERRUN    <= 1'b0;
      BYTE_COUNT <= 8'h00;
    end else begin
      if (csx_fall) begin
        BYTE_COUNT <= 8'h00;
        OVERRUN    <= 1'b0;
      end
      if (commit_reg) begin
        OUT    <= done_byte_reg;
        OUT_DC <= done_dc_reg;
        VALID  <= 1'b1;
        // An ACK landing on the commit cycle consumes the old byte, so no overrun.
        if (VALID && !ACK) begin
          OVERRUN <= 1'b1;
        end
        if (csx_fall) begin
          BYTE_COUNT <= 8'd1;
        end else if (BYTE_COUNT != 8'hFF) begin
          BYTE_COUNT <= BYTE_COUNT + 8'd1;
        end
      end else if (VALID && ACK) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: MSB-first instance checked through a byte scoreboard,
// a second LSB-first instance checked directly for bit order.
module tb_spi_slave_rx;

  logic clk = 1'b0;
  logic rst, sck, csx, sdi, dc, ack;
  logic [7:0] out_m, bc_m, out_l, bc_l;
  logic dc_m, valid_m, ovr_m, busy_m;
  logic dc_l, valid_l, ovr_l, busy_l;

  int vectors = 0;
  int miscompares = 0;
  int commits = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
    .CLK_100MHz(clk), .RESET(rst), .SCK(sck), .CSX(csx), .SDI(sdi), .DC(dc), .ACK(ack),
    .OUT(out_m), .OUT_DC(dc_m), .VALID(valid_m), .OVERRUN(ovr_m), .BUSY(busy_m),
    .BYTE_COUNT(bc_m)
  );

  spi_slave_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK_100MHz(clk), .RESET(rst), .SCK(sck), .CSX(csx), .SDI(sdi), .DC(dc), .ACK(ack),
    .OUT(out_l), .OUT_DC(dc_l), .VALID(valid_l), .OVERRUN(ovr_l), .BUSY(busy_l),
    .BYTE_COUNT(bc_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a commit shows up as VALID rising or BYTE_COUNT stepping by one.
  logic       v_prev  = 1'b0;
  logic [7:0] bc_prev = 8'h00;
  always @(negedge clk) begin
    if (!rst && ((valid_m && !v_prev) || (bc_m == 8'(bc_prev + 8'd1)))) begin
      commits++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_underflow: observed byte %02h expected none", out_m);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("sb_out", out_m, e[7:0]);
        check("sb_out_dc", dc_m, e[8]);
        $display("byte %0d: OUT=%02h OUT_DC=%0b expected %02h/%0b", commits, out_m, dc_m, e[7:0], e[8]);
      end
    end
    v_prev  <= valid_m;
    bc_prev <= bc_m;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: plain bit; 1: check VALID latency on this edge; 2: ACK on the commit cycle.
  task automatic send_bit(input logic b, input logic d, input int mode);
    sdi = b;
    dc  = d;
    tick(5);
    sck = 1'b1;
    if (mode == 1) begin
      tick(3);
      check("valid_before_latency", valid_m, 1'b0);
      tick(1);
      check("valid_at_latency", valid_m, 1'b1);
      tick(1);
    end else if (mode == 2) begin
      tick(3);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      tick(1);
    end else begin
      tick(5);
    end
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic d, input int mode);
    exp_q.push_back({d, v});
    for (int i = 7; i >= 0; i--) send_bit(v[i], d, (i == 0) ? mode : 0);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic frame_start();
    csx = 1'b0;
    tick(5);
  endtask

  task automatic frame_end();
    csx = 1'b1;
    tick(5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    rst = 1'b1; sck = 1'b0; csx = 1'b1; sdi = 1'b0; dc = 1'b0; ack = 1'b0;
    tick(2);
    check("rst_out", out_m, 8'h00);
    check("rst_out_dc", dc_m, 1'b0);
    check("rst_valid", valid_m, 1'b0);
    check("rst_overrun", ovr_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    check("rst_byte_count", bc_m, 8'h00);
    rst = 1'b0;
    tick(2);

    // Single byte with latency and BUSY timing
    csx = 1'b0;
    tick(1);
    check("busy_before_sync", busy_m, 1'b0);
    tick(1);
    check("busy_after_sync", busy_m, 1'b1);
    tick(3);
    send_byte(8'hA5, 1'b0, 1);
    check("single_count", bc_m, 8'd1);
    check("single_valid_held", valid_m, 1'b1);
    ack_pulse();
    check("single_valid_after_ack", valid_m, 1'b0);

    // Alternating stream in a fresh frame
    frame_end();
    frame_start();
    for (int k = 0; k < 4; k++) begin
      send_byte(8'hA5, 1'b0, 0);
      ack_pulse();
      send_byte(8'h5A, 1'b0, 0);
      ack_pulse();
    end
    check("stream_count", bc_m, 8'd8);
    check("stream_overrun", ovr_m, 1'b0);
    frame_end();
    check("stream_busy_low", busy_m, 1'b0);
    frame_start();
    check("stream_count_cleared", bc_m, 8'd0);

    // Overrun, then ACK coinciding with the commit
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    check("ovr_out", out_m, 8'h22);
    check("ovr_valid", valid_m, 1'b1);
    check("ovr_flag", ovr_m, 1'b1);
    check("ovr_count", bc_m, 8'd2);
    frame_end();
    check("ovr_valid_kept_csx_high", valid_m, 1'b1);
    frame_start();
    check("ovr_cleared_by_frame", ovr_m, 1'b0);
    check("ovr_count_cleared", bc_m, 8'd0);
    check("ovr_valid_kept_frame", valid_m, 1'b1);
    ack_pulse();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 2);
    check("ackcommit_overrun", ovr_m, 1'b0);
    check("ackcommit_valid", valid_m, 1'b1);
    check("ackcommit_out", out_m, 8'h22);
    ack_pulse();

    // Aborted byte
    frame_end();
    frame_start();
    c0 = commits;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 0);
    frame_end();
    frame_start();
    send_byte(8'h3C, 1'b0, 0);
    tick(2);
    check("abort_single_commit", commits, c0 + 1);
    check("abort_out", out_m, 8'h3C);
    check("abort_count", bc_m, 8'd1);
    ack_pulse();

    // DC tagging and LSB-first bit order
    frame_end();
    frame_start();
    send_byte(8'h2A, 1'b1, 0);
    check("lsb_out_2a", out_l, 8'h54);
    check("lsb_dc_2a", dc_l, 1'b1);
    check("lsb_valid_2a", valid_l, 1'b1);
    ack_pulse();
    send_byte(8'h01, 1'b0, 0);
    check("lsb_out_01", out_l, 8'h80);
    check("lsb_dc_01", dc_l, 1'b0);
    ack_pulse();

    // Reset during bit 4 with a byte pending
    send_byte(8'h77, 1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 0);
    sdi = 1'b1;
    tick(5);
    sck = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", out_m, 8'h00);
    check("midrst_out_dc", dc_m, 1'b0);
    check("midrst_valid", valid_m, 1'b0);
    check("midrst_overrun", ovr_m, 1'b0);
    check("midrst_busy", busy_m, 1'b0);
    check("midrst_count", bc_m, 8'h00);
    sck = 1'b0;
    csx = 1'b1;
    sdi = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    frame_start();
    send_byte(8'hFF, 1'b0, 0);
    check("post_rst_out", out_m, 8'hFF);
    check("post_rst_count", bc_m, 8'd1);
    ack_pulse();
    frame_end();

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
